// File: rtl/deser_queue_pkg.sv
// Shared types for the serial-to-parallel word queue.
// The PARITY state exists only when DESER_PARITY_EN is defined.
package deser_queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef DESER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_e;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_queue.sv
// Circular word queue with occupancy count; storage is not reset.
// A pop frees a slot in the same cycle, so push+pop while full is accepted.
module sync_queue import deser_queue_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [len_w(DEPTH)-1:0]    count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int LW = len_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/deser_queue.sv
// Serial bit deserializer feeding a word queue, with edge-detected strobes.
// Define DESER_PARITY_EN to append and check an even-parity bit per word.
module deser_queue import deser_queue_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    data_in,
  input  logic                    write_in,
  input  logic                    dequeue_in,
  output logic                    status_out,
  output logic [WIDTH-1:0]        data_out,
  output logic [len_w(DEPTH)-1:0] len_out,
  output logic                    overflow_out,
  output logic                    parity_err_out
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q, sh_d, data_q, head, word_data;
  logic             wr_q, deq_q, ovf_q;
  logic             wr_rise, deq_rise, word_done, word_ok, pop_ok, full, empty;

  assign wr_rise  = write_in & ~wr_q;
  assign deq_rise = dequeue_in & ~deq_q;
  assign sh_d     = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], data_in}
                                     : {data_in, sh_q[WIDTH-1:1]};
  assign pop_ok   = deq_rise & ~empty;

`ifdef DESER_PARITY_EN
  logic perr_q, par_bad;
  assign par_bad        = (data_in != ^sh_q);
  assign word_done      = wr_rise && (state_q == PARITY);
  assign word_ok        = word_done & ~par_bad;
  assign word_data      = sh_q;
  assign parity_err_out = perr_q;
`else
  // The word is pushed on the same edge that captures its last bit.
  assign word_done      = wr_rise && (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign word_ok        = word_done;
  assign word_data      = sh_d;
  assign parity_err_out = 1'b0;
`endif

  sync_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_queue (
    .clock       (clock),
    .reset       (reset),
    .push_i      (word_ok),
    .push_data_i (word_data),
    .pop_i       (pop_ok),
    .head_o      (head),
    .count_o     (len_out),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      deq_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      wr_q  <= write_in;
      deq_q <= dequeue_in;
`ifdef DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (pop_ok) data_q <= head;
      if (word_ok && full && !pop_ok) ovf_q <= 1'b1;
      if (wr_rise) begin
        case (state_q)
          IDLE: begin
            sh_q    <= sh_d;
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end
          SHIFT: begin
            sh_q <= sh_d;
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
              cnt_q   <= CW'(WIDTH);
              state_q <= PARITY;
`else
              cnt_q   <= '0;
              state_q <= IDLE;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef DESER_PARITY_EN
          PARITY: begin
            perr_q  <= par_bad;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
`endif
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign data_out     = data_q;
  assign overflow_out = ovf_q;
  assign status_out   = ~full;

endmodule

// File: doc/deser_queue.md
DESER_QUEUE -- requirements
Module: deser_queue

Interface
- REQ-001: Parameter WIDTH, default 8, word width in bits (SHALL be at least 2).
- REQ-002: Parameter DEPTH, default 8, queue capacity in words (SHALL be at least 2; need not be a power of two).
- REQ-003: Parameter MSB_FIRST, default 1, serial bit order: 1 = first bit received lands in data_out[WIDTH-1]; 0 = first bit lands in bit 0.
- REQ-004: clock  in  1  single clock for the whole block.
- REQ-005: reset  in  1  asynchronous, active-high reset.
- REQ-006: data_in  in  1  serial data bit, sampled on a write_in rising edge.
- REQ-007: write_in  in  1  bit strobe; level may be held for any number of cycles.
- REQ-008: dequeue_in  in  1  pop request; level may be held for any number of cycles.
- REQ-009: status_out  out  1  high when the queue can accept a word (not full).
- REQ-010: data_out  out  WIDTH  last popped word.
- REQ-011: len_out  out  $clog2(DEPTH+1)  number of words currently queued.
- REQ-012: overflow_out  out  1  sticky flag: a completed word was dropped because the queue was full.
- REQ-013: parity_err_out  out  1  one-cycle pulse: a word was dropped on a parity mismatch.

Function
- REQ-014: write_in and dequeue_in SHALL each be edge-detected against a registered copy; one action per 0->1 transition.
- REQ-015: The FSM SHALL use states IDLE (bit count 0), SHIFT (collecting bits) and PARITY (present only with DESER_PARITY_EN).
- REQ-016: On each write_in edge, data_in SHALL be shifted in according to MSB_FIRST and the bit counter incremented.
- REQ-017: At the clock edge that captures bit WIDTH (non-parity build), the word SHALL be pushed; len_out updates at that same edge; FSM returns to IDLE.
- REQ-018: A word completed while full SHALL be dropped, overflow_out set until reset, and len_out left unchanged.
- REQ-019: A dequeue_in edge with len_out>0 SHALL load the head word into data_out at that clock edge and decrement len_out.
- REQ-020: data_out SHALL hold its value until the next successful pop.
- REQ-021: A dequeue_in edge while empty SHALL be ignored, leaving data_out and len_out unchanged.
- REQ-022: A push and a pop at the same edge SHALL both occur and leave len_out unchanged; this holds even when full, so the word is accepted and overflow_out is not set.
- REQ-023: Read and write pointers SHALL wrap from DEPTH-1 to 0.
- REQ-024: status_out SHALL equal (len_out != DEPTH).

Reset
- REQ-025: Reset SHALL asynchronously clear data_out, len_out, overflow_out, parity_err_out, the pointers, the bit counter and both edge registers, and force the FSM to IDLE.
- REQ-026: status_out SHALL be 1 during reset.
- REQ-027: A partial word in progress when reset asserts SHALL be discarded.
- REQ-028: Queue storage contents SHALL NOT need to be reset.

Configuration
- REQ-029: With DESER_PARITY_EN defined, each word SHALL be WIDTH+1 serial bits, the last being an even-parity bit over the data bits.
- REQ-030: With DESER_PARITY_EN defined, a mismatch SHALL drop the word and pulse parity_err_out for one cycle; the push occurs at the parity-bit edge.
- REQ-031: Without DESER_PARITY_EN, the PARITY state SHALL be absent and parity_err_out SHALL be tied to 0; the port remains.

Structure
- REQ-032: Package deser_queue_pkg SHALL hold the FSM state enum and the helper function computing the len_out width.
- REQ-033: Queue storage and pointers SHALL be sub-module sync_queue, parametrised by WIDTH and DEPTH; deser_queue holds the edge detectors, FSM and shifter.

Verification
- REQ-034: Reset, then 8 words 0x80..0x87 sent MSB-first with write_in held 10 cycles per bit -> len_out counts to 8 and status_out falls to 0 after the 8th word.
- REQ-035: From that full state, send a 9th word 0x88 -> dropped, overflow_out=1, len_out=8.
- REQ-036: 8 dequeue_in pulses of 200 cycles each -> data_out 0x80..0x87 in order, len_out reaches 0; a 9th pulse leaves data_out=0x87.
- REQ-037: With len_out=DEPTH, complete a word in the same cycle as a dequeue edge -> len_out stays at DEPTH and overflow_out stays 0.
- REQ-038: Assert reset after 4 bits of a word -> len_out=0; the next 8 bits form a clean word 0xA5.
- REQ-039: With DESER_PARITY_EN, send 0x03 with parity bit 1 -> parity_err_out pulses once and len_out is unchanged; with parity bit 0 -> the word is queued.
